// File: rtl/lc4_regfile_pkg.sv
// Shared definitions for the LC4 register-file write-port logic:
// controller state encoding and register-file geometry.
package lc4_regfile_pkg;
  localparam int NUM_REGS  = 8;
  localparam int REG_SEL_W = 3;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;
endpackage

// File: rtl/Nbit_reg.sv
// Generic n-bit register with write enable, global write enable and
// synchronous active-low reset to a parameterised value.
module Nbit_reg #(
  parameter int           n = 1,
  parameter logic [n-1:0] r = '0
) (
  input  logic [n-1:0] in,
  output logic [n-1:0] out,
  input  logic         clk,
  input  logic         we,
  input  logic         gwe,
  input  logic         rst
);
  always_ff @(posedge clk) begin
    if (!rst)
      out <= r;
    else if (gwe && we)
      out <= in;
  end
endmodule

// File: rtl/lc4_dbg_wbuf.sv
// One-entry debug write buffer with a saturating wait counter; starve
// rises once the entry has been blocked STARVE_LIMIT gwe cycles.
module lc4_dbg_wbuf
  import lc4_regfile_pkg::*;
#(
  parameter int n            = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gwe,
  input  logic                 load,
  input  logic                 pop,
  input  logic [REG_SEL_W-1:0] in_rd,
  input  logic [n-1:0]         in_wdata,
  output logic                 buf_full,
  output logic                 starve,
  output logic [REG_SEL_W-1:0] buf_rd,
  output logic [n-1:0]         buf_wdata
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             full_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // load and pop are never asserted together (load needs an empty buffer)
  always_comb begin
    full_next = buf_full;
    cnt_next  = cnt;
    if (pop) begin
      full_next = 1'b0;
      cnt_next  = '0;
    end else if (load) begin
      full_next = 1'b1;
      cnt_next  = '0;
    end else if (buf_full && cnt != LIMIT) begin
      cnt_next = cnt + 1'b1;
    end
  end

  assign starve = buf_full & (cnt == LIMIT);

  Nbit_reg #(.n(1)) full_reg (
    .in(full_next), .out(buf_full), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst)
  );
  Nbit_reg #(.n(CNT_W)) cnt_reg (
    .in(cnt_next), .out(cnt), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst)
  );
  Nbit_reg #(.n(REG_SEL_W)) rd_reg (
    .in(in_rd), .out(buf_rd), .clk(clk), .we(load), .gwe(gwe), .rst(rst)
  );
  Nbit_reg #(.n(n)) wdata_reg (
    .in(in_wdata), .out(buf_wdata), .clk(clk), .we(load), .gwe(gwe), .rst(rst)
  );
endmodule

// File: rtl/lc4_regfile_wport_ctrl.sv
// Write-port owner for the LC4 register file: zero-fill sequencer after
// reset/soft-clear, then writeback/debug arbitration with starvation relief.
module lc4_regfile_wport_ctrl
  import lc4_regfile_pkg::*;
#(
  parameter int n            = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gwe,
  input  logic                 i_clear,
  input  logic                 i_wb_we,
  input  logic [REG_SEL_W-1:0] i_wb_rd,
  input  logic [n-1:0]         i_wb_wdata,
  output logic                 o_wb_stall,
  input  logic                 i_dbg_valid,
  input  logic [REG_SEL_W-1:0] i_dbg_rd,
  input  logic [n-1:0]         i_dbg_wdata,
  output logic                 o_dbg_ready,
  output logic                 o_dbg_done,
  output logic [REG_SEL_W-1:0] o_rd,
  output logic [n-1:0]         o_wdata,
  output logic                 o_rd_we,
  output logic                 o_busy,
  output logic                 o_proto_err
);
  logic                 state_q;
  state_t               state;
  state_t               state_next;
  logic [REG_SEL_W-1:0] idx;
  logic [REG_SEL_W-1:0] idx_next;
  logic                 err;
  logic                 err_next;
  logic                 run;
  logic                 dbg_grant;
  logic                 drop;
  logic                 accept;
  logic                 buf_full;
  logic                 starve;
  logic [REG_SEL_W-1:0] buf_rd;
  logic [n-1:0]         buf_wdata;

  assign state = state_t'(state_q);
  // While rst is low the registers may still hold RUN; outputs must look like CLEAR idx 0.
  assign run   = rst & (state == RUN);

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    err_next    = err;
    dbg_grant   = 1'b0;
    drop        = 1'b0;
    o_rd        = i_wb_rd;
    o_wdata     = i_wb_wdata;
    o_rd_we     = i_wb_we;
    o_wb_stall  = 1'b0;
    o_busy      = 1'b0;
    o_dbg_ready = 1'b0;
    o_dbg_done  = 1'b0;
    if (!run) begin
      o_rd       = rst ? idx : '0;
      o_wdata    = '0;
      o_rd_we    = 1'b1;
      o_wb_stall = 1'b1;
      o_busy     = 1'b1;
      idx_next   = idx + 1'b1;
      if (idx == REG_SEL_W'(NUM_REGS - 1)) begin
        state_next = RUN;
        idx_next   = '0;
      end
      if (i_wb_we)
        err_next = 1'b1;
    end else begin
      o_wb_stall  = starve;
      dbg_grant   = buf_full & (starve | ~i_wb_we);
      o_dbg_ready = ~buf_full & ~i_clear & gwe;
      if (dbg_grant) begin
        o_rd       = buf_rd;
        o_wdata    = buf_wdata;
        o_rd_we    = 1'b1;
        o_dbg_done = gwe;
      end
      if (i_wb_we && starve)
        err_next = 1'b1;
      // A granted debug write still issues this cycle; only a blocked entry is lost.
      if (i_clear) begin
        state_next = CLEAR;
        idx_next   = '0;
        drop       = 1'b1;
      end
    end
  end

  assign accept      = o_dbg_ready & i_dbg_valid;
  assign o_proto_err = err & rst;

  Nbit_reg #(.n(1), .r(1'b0)) state_reg (
    .in(state_next), .out(state_q), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst)
  );
  Nbit_reg #(.n(REG_SEL_W)) idx_reg (
    .in(idx_next), .out(idx), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst)
  );
  Nbit_reg #(.n(1)) err_reg (
    .in(err_next), .out(err), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst)
  );

  lc4_dbg_wbuf #(.n(n), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_wbuf (
    .clk(clk), .rst(rst), .gwe(gwe),
    .load(accept), .pop(dbg_grant | drop),
    .in_rd(i_dbg_rd), .in_wdata(i_dbg_wdata),
    .buf_full(buf_full), .starve(starve),
    .buf_rd(buf_rd), .buf_wdata(buf_wdata)
  );
endmodule

// File: tb/tb_lc4_regfile_wport_ctrl.sv
// Directed + randomized bench for lc4_regfile_wport_ctrl against a
// transaction-level model of the fill sequence, port owner and debug queue.
module tb_lc4_regfile_wport_ctrl;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst, gwe, i_clear, i_wb_we, i_dbg_valid;
  logic [2:0]  i_wb_rd, i_dbg_rd;
  logic [15:0] i_wb_wdata, i_dbg_wdata;
  logic        o_wb_stall, o_dbg_ready, o_dbg_done, o_rd_we, o_busy, o_proto_err;
  logic [2:0]  o_rd;
  logic [15:0] o_wdata;

  int errors = 0;
  int checks = 0;

  // model state: fill progress, pending debug entry, blocked-cycle count
  bit          m_filling;
  int          m_fill_pos;
  bit          m_pending;
  logic [2:0]  m_prd;
  logic [15:0] m_pdata;
  int          m_blocked;
  bit          m_err;

  always #5 clk = ~clk;

  lc4_regfile_wport_ctrl #(.n(16), .STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .gwe(gwe), .i_clear(i_clear),
    .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_wdata(i_wb_wdata),
    .o_wb_stall(o_wb_stall),
    .i_dbg_valid(i_dbg_valid), .i_dbg_rd(i_dbg_rd), .i_dbg_wdata(i_dbg_wdata),
    .o_dbg_ready(o_dbg_ready), .o_dbg_done(o_dbg_done),
    .o_rd(o_rd), .o_wdata(o_wdata), .o_rd_we(o_rd_we),
    .o_busy(o_busy), .o_proto_err(o_proto_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_starving();
    return m_pending && (m_blocked >= LIMIT);
  endfunction

  function automatic bit m_dbg_writes();
    return !m_filling && m_pending && (m_starving() || !i_wb_we);
  endfunction

  task automatic model_check();
    bit in_fill;
    in_fill = !rst || m_filling;
    if (in_fill) begin
      check("rd",     {29'd0, o_rd}, rst ? m_fill_pos : 0);
      check("wdata",  {16'd0, o_wdata}, 0);
      check("rd_we",  {31'd0, o_rd_we}, 1);
      check("stall",  {31'd0, o_wb_stall}, 1);
      check("busy",   {31'd0, o_busy}, 1);
      check("ready",  {31'd0, o_dbg_ready}, 0);
      check("done",   {31'd0, o_dbg_done}, 0);
    end else begin
      if (m_dbg_writes()) begin
        check("rd",    {29'd0, o_rd}, {29'd0, m_prd});
        check("wdata", {16'd0, o_wdata}, {16'd0, m_pdata});
        check("rd_we", {31'd0, o_rd_we}, 1);
      end else begin
        check("rd_we", {31'd0, o_rd_we}, {31'd0, i_wb_we});
        if (i_wb_we) begin
          check("rd",    {29'd0, o_rd}, {29'd0, i_wb_rd});
          check("wdata", {16'd0, o_wdata}, {16'd0, i_wb_wdata});
        end
      end
      check("stall", {31'd0, o_wb_stall}, {31'd0, m_starving()});
      check("busy",  {31'd0, o_busy}, 0);
      check("ready", {31'd0, o_dbg_ready}, {31'd0, !m_pending && !i_clear && gwe});
      check("done",  {31'd0, o_dbg_done}, {31'd0, m_dbg_writes() && gwe});
    end
    check("perr", {31'd0, o_proto_err}, {31'd0, rst && m_err});
  endtask

  task automatic model_update();
    bit wrote, accepted;
    if (!rst) begin
      m_filling = 1; m_fill_pos = 0; m_pending = 0; m_blocked = 0; m_err = 0;
    end else if (gwe) begin
      if (m_filling) begin
        if (i_wb_we) m_err = 1;
        if (m_fill_pos == 7) begin m_filling = 0; m_fill_pos = 0; end
        else m_fill_pos++;
      end else begin
        if (i_wb_we && m_starving()) m_err = 1;
        wrote    = m_dbg_writes();
        accepted = !m_pending && !i_clear && i_dbg_valid;
        if (wrote) begin m_pending = 0; m_blocked = 0; end
        else if (m_pending && m_blocked < LIMIT) m_blocked++;
        if (accepted) begin
          m_pending = 1; m_prd = i_dbg_rd; m_pdata = i_dbg_wdata; m_blocked = 0;
        end
        if (i_clear) begin m_filling = 1; m_fill_pos = 0; m_pending = 0; m_blocked = 0; end
      end
    end
  endtask

  // one clock: settle, compare against model, advance model on the edge
  task automatic tick();
    #1;
    model_check();
    $display("cyc rst=%0b gwe=%0b clr=%0b wb=%0b:%0d:%h dbg=%0b:%0d:%h -> we=%0b rd=%0d wd=%h st=%0b rdy=%0b dn=%0b bsy=%0b err=%0b",
             rst, gwe, i_clear, i_wb_we, i_wb_rd, i_wb_wdata, i_dbg_valid, i_dbg_rd, i_dbg_wdata,
             o_rd_we, o_rd, o_wdata, o_wb_stall, o_dbg_ready, o_dbg_done, o_busy, o_proto_err);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    gwe = 1; i_clear = 0; i_wb_we = 0; i_wb_rd = 0; i_wb_wdata = 0;
    i_dbg_valid = 0; i_dbg_rd = 0; i_dbg_wdata = 0;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    m_filling = 1; m_fill_pos = 0; m_pending = 0; m_blocked = 0; m_err = 0;
    m_prd = 0; m_pdata = 0;
    @(negedge clk);

    // reset cycle, then the 8-cycle fill
    #1;
    check("rst_busy", {31'd0, o_busy}, 1);
    check("rst_rd_we", {31'd0, o_rd_we}, 1);
    tick();
    rst = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("fill_rd", {29'd0, o_rd}, k);
      tick();
    end
    #1;
    check("fill_done_busy", {31'd0, o_busy}, 0);
    check("fill_done_ready", {31'd0, o_dbg_ready}, 1);
    check("fill_done_we", {31'd0, o_rd_we}, 0);
    tick();

    // writeback passthrough
    i_wb_we = 1; i_wb_rd = 3; i_wb_wdata = 16'hBEEF;
    #1;
    check("wb_rd", {29'd0, o_rd}, 3);
    check("wb_wdata", {16'd0, o_wdata}, 32'hBEEF);
    check("wb_stall", {31'd0, o_wb_stall}, 0);
    tick();

    // idle debug write: accept at N, write at N+1, ready again at N+2
    i_wb_we = 0; i_dbg_valid = 1; i_dbg_rd = 5; i_dbg_wdata = 16'h1234;
    #1;
    check("dbg_accept_ready", {31'd0, o_dbg_ready}, 1);
    tick();
    i_dbg_valid = 0;
    #1;
    check("dbg_done", {31'd0, o_dbg_done}, 1);
    check("dbg_rd", {29'd0, o_rd}, 5);
    check("dbg_wdata", {16'd0, o_wdata}, 32'h1234);
    tick();
    #1;
    check("dbg_ready_again", {31'd0, o_dbg_ready}, 1);
    tick();

    // starvation: writeback every cycle, forced grant on the 5th
    i_dbg_valid = 1; i_dbg_rd = 2; i_dbg_wdata = 16'h00AA; i_wb_we = 1;
    tick();
    i_dbg_valid = 0;
    for (int k = 0; k < LIMIT; k++) begin
      i_wb_rd = 3'($urandom_range(7, 0)); i_wb_wdata = 16'($urandom);
      #1;
      check("starve_wb_wins", {31'd0, o_dbg_done}, 0);
      tick();
    end
    #1;
    check("starve_stall", {31'd0, o_wb_stall}, 1);
    check("starve_rd", {29'd0, o_rd}, 2);
    check("starve_wdata", {16'd0, o_wdata}, 32'h00AA);
    tick();
    #1;
    check("starve_unstall", {31'd0, o_wb_stall}, 0);
    check("proto_err_set", {31'd0, o_proto_err}, 1);
    tick();

    // soft clear with a blocked pending entry, gwe gap mid-fill
    i_dbg_valid = 1; i_dbg_rd = 6; i_dbg_wdata = 16'h5A5A;
    tick();
    i_dbg_valid = 0; i_clear = 1;
    tick();
    i_clear = 0; i_wb_we = 0;
    for (int k = 0; k < 11; k++) begin
      gwe = (k >= 4 && k < 7) ? 1'b0 : 1'b1;
      #1;
      check("clr_no_done", {31'd0, o_dbg_done}, 0);
      check("clr_rd", {29'd0, o_rd}, (k < 4) ? k : (k < 7) ? 4 : k - 3);
      tick();
    end
    gwe = 1;
    #1;
    check("clr_exit_busy", {31'd0, o_busy}, 0);
    check("proto_err_sticky", {31'd0, o_proto_err}, 1);
    tick();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst         = ($urandom_range(99, 0) < 2) ? 1'b0 : 1'b1;
      gwe         = ($urandom_range(99, 0) < 80);
      i_clear     = ($urandom_range(99, 0) < 3);
      i_wb_we     = ($urandom_range(99, 0) < 55);
      i_wb_rd     = 3'($urandom_range(7, 0));
      i_wb_wdata  = 16'($urandom);
      i_dbg_valid = ($urandom_range(99, 0) < 50);
      i_dbg_rd    = 3'($urandom_range(7, 0));
      i_dbg_wdata = 16'($urandom);
      tick();
    end

    // reset clears the sticky error
    idle_inputs();
    rst = 0;
    #1;
    check("rst_err_clear", {31'd0, o_proto_err}, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
